// File: rtl/adc_cap_reader.sv
// BRAM-to-AXI4-Stream readout engine with credit-limited reads into a small output FIFO.
// Optional leading header beat when ADC_CAP_READER_HDR_EN is defined.
module adc_cap_reader #(
    parameter int DWIDTH     = 256,
    parameter int MAX_XFER   = 2048,
    parameter int RD_LATENCY = 2
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start_i,
    input  logic [$clog2(MAX_XFER):0] len_i,
    input  logic                     cap_done_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     start_err_o,
    output logic [31:0]              bram_addr,
    output logic                     bram_en,
    output logic [DWIDTH/8-1:0]      bram_we,
    output logic [DWIDTH-1:0]        bram_wdata,
    input  logic [DWIDTH-1:0]        bram_rdata,
    output logic                     bram_clk,
    output logic                     bram_rst,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);
    localparam int ADDR_BITS  = $clog2(MAX_XFER);
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int IW         = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0]   MAX_C   = (ADDR_BITS+1)'(MAX_XFER);
    localparam logic [ADDR_BITS:0]   LEN_ONE = (ADDR_BITS+1)'(1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_BITS:0]    r_len;
    logic [ADDR_BITS:0]    r_issued;
    logic [ADDR_BITS:0]    r_push_idx;
    logic [ADDR_BITS-1:0]  r_bram_addr;
    logic                  r_bram_en;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [DWIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_start_err;

    logic                  w_accept;
    logic [ADDR_BITS:0]    w_len_eff;
    logic                  w_pop;
    logic                  w_push_data;
    logic                  w_push_hdr;
    logic [DWIDTH-1:0]     w_hdr;
    logic [CW-1:0]         w_inflight;
    logic                  w_issue;
    logic [RD_LATENCY:0]   w_pipe_in;
    logic [DWIDTH-1:0]     w_mem_nxt [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] w_last_nxt;
    logic [CW-1:0]         w_cnt_nxt;

    assign w_accept    = (r_state == S_IDLE) && start_i && cap_done_i;
    assign w_len_eff   = ((len_i == {(ADDR_BITS+1){1'b0}}) || (len_i > MAX_C)) ? MAX_C : len_i;
    assign w_pop       = r_tvalid && m_axis_tready;
    assign w_push_data = r_rd_pipe[RD_LATENCY-1];
    assign w_pipe_in   = {r_rd_pipe, r_bram_en};

`ifdef ADC_CAP_READER_HDR_EN
    logic [31:0] r_seq;
    assign w_push_hdr = w_accept;

    // Header beat contents for the readout being accepted
    always_comb begin
        w_hdr = {DWIDTH{1'b0}};
        w_hdr[DWIDTH-1 -: 32]  = 32'hADC0_CAFE;
        w_hdr[DWIDTH-33 -: 32] = r_seq;
        w_hdr[ADDR_BITS:0]     = w_len_eff;
    end

    // Readout sequence number, advanced once per completed packet
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_seq <= 32'd0;
        end else if (r_done) begin
            r_seq <= r_seq + 32'd1;
        end
    end
`else
    assign w_push_hdr = 1'b0;
    assign w_hdr      = {DWIDTH{1'b0}};
`endif

    // Words outstanding beyond the FIFO: the read on the BRAM port plus the latency pipe
    always_comb begin
        w_inflight = CW'(r_bram_en);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_rd_pipe[i]);
        end
    end

    // A word popped this cycle frees its credit for the read decided now
    assign w_issue = w_accept ||
                     ((r_state == S_RUN) && (r_issued < r_len) &&
                      ((r_cnt + w_inflight) < (DEPTH_C + CW'(w_pop))));

    // Shift-down FIFO next state; entry 0 is the stream output register
    always_comb begin
        w_mem_nxt  = r_mem;
        w_last_nxt = r_last;
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_mem_nxt[i]  = r_mem[i+1];
                w_last_nxt[i] = r_last[i+1];
            end
            w_mem_nxt[FIFO_DEPTH-1]  = {DWIDTH{1'b0}};
            w_last_nxt[FIFO_DEPTH-1] = 1'b0;
            w_cnt_nxt = r_cnt - CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
        if (w_push_hdr || w_push_data) begin
            w_mem_nxt[w_cnt_nxt[IW-1:0]]  = w_push_hdr ? w_hdr : bram_rdata;
            w_last_nxt[w_cnt_nxt[IW-1:0]] = w_push_data && (r_push_idx == (r_len - LEN_ONE));
            w_cnt_nxt = w_cnt_nxt + CW'(1);
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // FIFO storage and stream valid
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DWIDTH{1'b0}};
            end
            r_last   <= {FIFO_DEPTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_tvalid <= 1'b0;
        end else begin
            r_mem    <= w_mem_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tvalid <= (w_cnt_nxt != {CW{1'b0}});
        end
    end

    // Read issue: address, enable, latency pipe and counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= {ADDR_BITS{1'b0}};
            r_issued    <= {(ADDR_BITS+1){1'b0}};
            r_push_idx  <= {(ADDR_BITS+1){1'b0}};
            r_rd_pipe   <= {RD_LATENCY{1'b0}};
        end else begin
            r_bram_en <= w_issue;
            r_rd_pipe <= w_pipe_in[RD_LATENCY-1:0];
            if (w_accept) begin
                r_bram_addr <= {ADDR_BITS{1'b0}};
                r_issued    <= LEN_ONE;
                r_push_idx  <= {(ADDR_BITS+1){1'b0}};
            end else begin
                if (w_issue) begin
                    r_bram_addr <= r_issued[ADDR_BITS-1:0];
                    r_issued    <= r_issued + LEN_ONE;
                end
                if (w_push_data) begin
                    r_push_idx <= r_push_idx + LEN_ONE;
                end
            end
        end
    end

    // Control FSM and status pulses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_len       <= {(ADDR_BITS+1){1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_start_err <= (r_state == S_IDLE) && start_i && !cap_done_i;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_len   <= w_len_eff;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_pop && r_last[0]) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign start_err_o   = r_start_err;
    assign bram_addr     = {{(32-ADDR_BITS){1'b0}}, r_bram_addr};
    assign bram_en       = r_bram_en;
    assign bram_we       = {(DWIDTH/8){1'b0}};
    assign bram_wdata    = {DWIDTH{1'b0}};
    assign bram_clk      = aclk;
    assign bram_rst      = ~aresetn;
    assign m_axis_tdata  = r_mem[0];
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_last[0];
endmodule

// File: tb/tb_adc_cap_reader.sv
// Self-checking bench for adc_cap_reader: BRAM model, stream monitor and packet reference model.
module tb_adc_cap_reader;
    localparam int DW   = 256;
    localparam int MAXX = 2048;
    localparam int LAT  = 2;
    localparam int AB   = 11;
`ifdef ADC_CAP_READER_HDR_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic aclk, aresetn, start_i, cap_done_i, busy_o, done_o, start_err_o;
    logic [AB:0] len_i;
    logic [31:0] bram_addr;
    logic bram_en, bram_clk, bram_rst;
    logic [DW/8-1:0] bram_we;
    logic [DW-1:0] bram_wdata, bram_rdata, m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready, m_axis_tlast;

    adc_cap_reader #(.DWIDTH(DW), .MAX_XFER(MAXX), .RD_LATENCY(LAT)) dut (
        .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .len_i(len_i),
        .cap_done_i(cap_done_i), .busy_o(busy_o), .done_o(done_o),
        .start_err_o(start_err_o), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // BRAM model with a two-cycle read
    logic [DW-1:0] mem [MAXX];
    logic [DW-1:0] p1;
    always @(posedge aclk) begin
        if (bram_en) p1 <= mem[bram_addr[AB-1:0]];
        else         p1 <= {DW{1'bx}};
        bram_rdata <= p1;
    end

    int total = 0;
    int bad = 0;
    logic mon_clr = 1'b0;
    int cyc, en_cnt, acc_cnt, max_out, stall_viol, err_cnt, done_cnt;
    int first_en_cyc, start_cyc, done_cyc, last_addr;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] beats[$];
    logic blast[$];
    int bcyc[$];
    logic [DW-1:0] exp_q[$];
`ifdef ADC_CAP_READER_HDR_EN
    logic [31:0] seq_model = 32'd0;
`endif

    // Stream / BRAM-port monitor sampled on the falling edge
    always @(negedge aclk) begin
        if (mon_clr) begin
            cyc <= 0; en_cnt <= 0; acc_cnt <= 0; max_out <= 0; stall_viol <= 0;
            err_cnt <= 0; done_cnt <= 0; first_en_cyc <= -1; start_cyc <= -1;
            done_cyc <= -1; last_addr <= -1; prev_stall <= 1'b0;
            prev_last <= 1'b0; prev_data <= {DW{1'b0}};
            beats.delete(); blast.delete(); bcyc.delete();
        end else begin
            cyc <= cyc + 1;
            if (bram_en) begin
                en_cnt <= en_cnt + 1;
                last_addr <= int'(bram_addr);
                if (first_en_cyc < 0) first_en_cyc <= cyc;
            end
            if (en_cnt + int'(bram_en) - acc_cnt > max_out) max_out <= en_cnt + int'(bram_en) - acc_cnt;
            if (m_axis_tvalid && m_axis_tready) begin
                acc_cnt <= acc_cnt + 1;
                beats.push_back(m_axis_tdata);
                blast.push_back(m_axis_tlast);
                bcyc.push_back(cyc);
            end
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
                stall_viol <= stall_viol + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_data  <= m_axis_tdata;
            prev_last  <= m_axis_tlast;
            if (start_i && start_cyc < 0) start_cyc <= cyc;
            if (start_err_o) err_cnt <= err_cnt + 1;
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic clear_mon();
        @(posedge aclk); #1 mon_clr = 1'b1;
        @(posedge aclk); #1 mon_clr = 1'b0;
    endtask

    // Expected packet: optional header, then BRAM words 0..eff-1
    task automatic build_exp(input int len);
        int eff;
        eff = (len == 0 || len > MAXX) ? MAXX : len;
        exp_q.delete();
`ifdef ADC_CAP_READER_HDR_EN
        begin
            logic [DW-1:0] hdr;
            hdr = {DW{1'b0}};
            hdr[255:224] = 32'hADC0CAFE;
            hdr[223:192] = seq_model;
            hdr[AB:0] = (AB+1)'(eff);
            exp_q.push_back(hdr);
        end
`endif
        for (int k = 0; k < eff; k++) exp_q.push_back(mem[k]);
    endtask

    function automatic int pkt_errs();
        int e = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= beats.size() || beats[k] !== exp_q[k] || blast[k] !== 1'(k == exp_q.size() - 1)) e++;
        if (beats.size() > exp_q.size()) e += beats.size() - exp_q.size();
        return e;
    endfunction

    // Start one readout, drive random tready, wait (bounded) for done_o
    task automatic run_pkt(input int len, input int pct, input int restart_at);
        clear_mon();
        build_exp(len);
        cap_done_i = 1'b1; len_i = (AB+1)'(len); start_i = 1'b1;
        m_axis_tready = ($urandom_range(0, 99) < pct);
        @(posedge aclk); #1 start_i = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (done_cnt != 0) break;
            m_axis_tready = ($urandom_range(0, 99) < pct);
            start_i = (n == restart_at);
            @(posedge aclk); #1;
        end
        start_i = 1'b0;
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL timeout len=%0d: done_o not seen, beats=%0d want %0d", len, beats.size(), exp_q.size());
        end
`ifdef ADC_CAP_READER_HDR_EN
        seq_model = seq_model + 32'd1;
`endif
        m_axis_tready = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; start_i = 1'b0; cap_done_i = 1'b0; len_i = '0; m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        total++;
        if ({busy_o, done_o, start_err_o, bram_en, m_axis_tvalid, m_axis_tlast} !== 6'b0 ||
            bram_addr !== 32'd0 || m_axis_tdata !== {DW{1'b0}} || bram_we !== '0 || bram_wdata !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
        end
        total++;
        if (bram_rst !== 1'b1 || bram_clk !== aclk) begin
            bad++; $display("FAIL reset_bram_pins: bram_rst=%b bram_clk=%b aclk=%b want rst=1 clk=aclk", bram_rst, bram_clk, aclk);
        end
        aresetn = 1'b1;
        #1;
        total++;
        if (bram_rst !== 1'b0) begin
            bad++; $display("FAIL bram_rst_release: got %b want 0", bram_rst);
        end
    endtask

    task automatic test_basic();
        int e;
        run_pkt(16, 100, -1);
        total++; e = pkt_errs();
        if (e != 0) begin bad++; $display("FAIL basic_data: %0d beat errors, got %0d beats want %0d", e, beats.size(), exp_q.size()); end
        total++;
        if (first_en_cyc !== start_cyc + 1) begin bad++; $display("FAIL basic_en_latency: got %0d want %0d", first_en_cyc - start_cyc, 1); end
`ifndef ADC_CAP_READER_HDR_EN
        total++;
        if (bcyc.size() == 0 || bcyc[0] !== start_cyc + LAT + 2) begin
            bad++; $display("FAIL basic_valid_latency: got %0d want %0d", bcyc.size() ? bcyc[0] - start_cyc : -1, LAT + 2);
        end
`endif
        total++;
        if (done_cyc !== start_cyc + 16 + LAT + 2) begin bad++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc - start_cyc, 16 + LAT + 2); end
        e = 0;
        for (int k = HOFF + 1; k < bcyc.size(); k++) if (bcyc[k] != bcyc[k-1] + 1) e++;
        total++;
        if (e != 0 || bcyc.size() != 16 + HOFF) begin bad++; $display("FAIL basic_no_bubbles: %0d gaps, %0d beats", e, bcyc.size()); end
        total++;
        if (busy_o !== 1'b0 || en_cnt != 16 || done_cnt != 1) begin
            bad++; $display("FAIL basic_after: busy=%b en=%0d done=%0d want 0/16/1", busy_o, en_cnt, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int e;
        run_pkt(0, 50, -1);
        total++; e = pkt_errs();
        if (e != 0) begin bad++; $display("FAIL bp_data: %0d beat errors, got %0d beats want %0d", e, beats.size(), exp_q.size()); end
        total++;
        if (max_out > LAT + 2) begin bad++; $display("FAIL bp_outstanding: got %0d want <= %0d", max_out, LAT + 2); end
        total++;
        if (stall_viol != 0) begin bad++; $display("FAIL bp_stall_stable: %0d unstable stalled cycles want 0", stall_viol); end
        total++;
        if (last_addr != MAXX - 1 || en_cnt != MAXX) begin bad++; $display("FAIL bp_last_addr: addr=%0d reads=%0d want %0d/%0d", last_addr, en_cnt, MAXX - 1, MAXX); end
    endtask

    task automatic test_reject();
        int e;
        clear_mon();
        cap_done_i = 1'b0; len_i = 12'd8; start_i = 1'b1;
        @(posedge aclk); #1 start_i = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        total++;
        if (err_cnt != 1 || en_cnt != 0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reject_start: err_cycles=%0d reads=%0d busy=%b want 1/0/0", err_cnt, en_cnt, busy_o);
        end
        run_pkt(16, 100, 3);
        total++; e = pkt_errs();
        if (e != 0) begin bad++; $display("FAIL restart_data: %0d beat errors, got %0d beats", e, beats.size()); end
        total++;
        if (err_cnt != 0 || done_cnt != 1 || en_cnt != 16) begin
            bad++; $display("FAIL restart_ignored: err=%0d done=%0d reads=%0d want 0/1/16", err_cnt, done_cnt, en_cnt);
        end
    endtask

    task automatic test_len_edges();
        int e;
        run_pkt(1, 100, -1);
        total++; e = pkt_errs();
        if (e != 0 || beats.size() != 1 + HOFF) begin bad++; $display("FAIL len1: %0d errors, %0d beats want %0d", e, beats.size(), 1 + HOFF); end
        run_pkt(3000, 70, -1);
        total++; e = pkt_errs();
        if (e != 0) begin bad++; $display("FAIL len3000_data: %0d errors, got %0d beats want %0d", e, beats.size(), exp_q.size()); end
        total++;
        if (last_addr != MAXX - 1 || en_cnt != MAXX) begin bad++; $display("FAIL len3000_addr: addr=%0d reads=%0d want %0d/%0d", last_addr, en_cnt, MAXX - 1, MAXX); end
    endtask

    task automatic test_reset_midop();
        int e;
        bit hit;
        clear_mon();
        cap_done_i = 1'b1; len_i = 12'd16; start_i = 1'b1; m_axis_tready = 1'b1;
        @(posedge aclk); #1 start_i = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (acc_cnt == 5) begin hit = 1'b1; break; end
            @(posedge aclk); #1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL midop_reach_beat5: accepted=%0d want 5", acc_cnt); end
        #1 aresetn = 1'b0;
        #1;
        total++;
        if ({busy_o, done_o, start_err_o, bram_en, m_axis_tvalid, m_axis_tlast} !== 6'b0 ||
            bram_addr !== 32'd0 || m_axis_tdata !== {DW{1'b0}}) begin
            bad++; $display("FAIL midop_reset_outputs: valid=%b en=%b busy=%b want all 0", m_axis_tvalid, bram_en, busy_o);
        end
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
`ifdef ADC_CAP_READER_HDR_EN
        seq_model = 32'd0;
`endif
        run_pkt(16, 100, -1);
        total++; e = pkt_errs();
        if (e != 0 || en_cnt != 16) begin bad++; $display("FAIL midop_clean_packet: %0d errors, %0d beats, %0d reads", e, beats.size(), en_cnt); end
    endtask

`ifdef ADC_CAP_READER_HDR_EN
    task automatic test_header();
        for (int p = 0; p < 2; p++) begin
            run_pkt(4, 100, -1);
            total++;
            if (beats.size() != 5 || pkt_errs() != 0) begin bad++; $display("FAIL hdr_packet%0d: %0d beats want 5", p, beats.size()); end
            total++;
            if (beats.size() == 0 || beats[0][255:224] !== 32'hADC0CAFE || beats[0][223:192] !== 32'(p) || beats[0][AB:0] !== 12'd4) begin
                bad++; $display("FAIL hdr_fields%0d: got %h want magic/seq %0d/len 4", p, beats.size() ? beats[0][255:192] : 64'd0, p);
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < MAXX; k++)
            mem[k] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 32'(k)};
        test_reset();
        test_basic();
        test_backpressure();
        test_reject();
        test_len_edges();
        test_reset_midop();
`ifdef ADC_CAP_READER_HDR_EN
        aresetn = 1'b0; #3 aresetn = 1'b1; seq_model = 32'd0;
        test_header();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_cap_reader.md
# adc_cap_reader

Readout engine that sits directly downstream of the ADC capture BRAM. Once the capture writer reports done, it reads the stored 256-bit words back out of the BRAM's second port and streams them as an AXI4-Stream packet toward the DMA/PS path. It tolerates arbitrary `m_axis_tready` backpressure against a fixed-latency BRAM read by tracking read credits into a small output FIFO.

## Interface

Parameters:
- `DWIDTH` (default 256): BRAM word width and stream width.
- `MAX_XFER` (default 2048): BRAM depth in words; must be a power of 2. `ADDR_BITS = $clog2(MAX_XFER)`.
- `RD_LATENCY` (default 2): BRAM read latency in cycles; legal values are 1 and 2.

Ports:
- `aclk` in, 1: the single clock for the block and the BRAM port.
- `aresetn` in, 1: asynchronous, active-low reset.
- `start_i` in, 1: single-cycle request to begin a readout.
- `len_i` in, ADDR_BITS+1: number of words to read; sampled on an accepted start.
- `cap_done_i` in, 1: high when the capture writer is idle and the BRAM contents are valid.
- `busy_o` out, 1: high from an accepted start until the final beat is accepted.
- `done_o` out, 1: one-cycle pulse after the final beat is accepted.
- `start_err_o` out, 1: one-cycle pulse when `start_i` is rejected.
- `bram_addr` out, 32: word address, zero-extended from ADDR_BITS.
- `bram_en` out, 1: read enable.
- `bram_we` out, DWIDTH/8: tied to 0.
- `bram_wdata` out, DWIDTH: tied to 0.
- `bram_rdata` in, DWIDTH: read data, valid RD_LATENCY cycles after the `bram_en` edge.
- `bram_clk` out, 1: driven as `aclk`.
- `bram_rst` out, 1: driven as `~aresetn`.
- `m_axis_tdata` out, DWIDTH: output stream data.
- `m_axis_tvalid` out, 1: output stream valid.
- `m_axis_tready` in, 1: output stream ready.
- `m_axis_tlast` out, 1: marks the final beat of the packet.

## Operation

States and transitions:
- IDLE → RUN on `start_i && cap_done_i`.
  - Latch the length: `len_i == 0` or `len_i > MAX_XFER` is treated as MAX_XFER.
  - Clear the read address and the beat counter.
- `start_i` while `!cap_done_i` in IDLE: no state change; pulse `start_err_o`.
- `start_i` while not in IDLE: ignored; no error pulse.
- RUN issues one read per cycle while `fifo_count + inflight < FIFO_DEPTH`, where `FIFO_DEPTH = RD_LATENCY + 2`.
  - Issuing a read means `bram_en` = 1 and the address increments.
  - No reads are issued once the latched length has been issued.
- Every returned read word is pushed into the FIFO. The FIFO never overflows because of the credit rule.
- The FIFO head drives `m_axis_*`. `m_axis_tlast` = 1 exactly on beat number len−1 (counting from 0).
- RUN → DONE when the tlast beat is accepted (`tvalid && tready`).
- DONE → IDLE after one cycle; `done_o` = 1 during DONE.

Arithmetic and boundaries:
- The address counter is ADDR_BITS wide.
- With len = MAX_XFER, the last address issued is MAX_XFER−1. No wrap read is issued.
- `cap_done_i` falling during RUN is ignored; the readout completes.
- Asynchronous reset at any point returns to IDLE, empties the FIFO, and discards in-flight reads.

## Timing

Reset values:
- All outputs are 0 except `bram_clk` and `bram_rst`.
- State is IDLE and the FIFO is empty.

Latency:
- The first `bram_en` is asserted in the cycle after the accepted start.
- The first `m_axis_tvalid` follows the first `bram_en` by RD_LATENCY+1 cycles.

Throughput:
- With `m_axis_tready` held high, the block delivers 1 beat per cycle with no bubbles.
- A len = N packet completes in N + RD_LATENCY + 2 cycles from the start cycle, plus any stalls.

AXI handshake:
- Once `tvalid` is asserted, `tvalid`, `tdata` and `tlast` hold stable until `tready` is high.
- `tvalid` never depends combinationally on `tready`.

Credit rule:
- During a stall, at most FIFO_DEPTH words are outstanding (in flight plus stored).
- `bram_en` is deasserted within 1 cycle of the credit limit being reached.

## Configuration

The header feature is controlled by the macro `ADC_CAP_READER_HDR_EN`.

- Defined: the packet carries one extra leading header beat.
  - `tdata[255:224]` = 32'hADC0CAFE.
  - `tdata[223:192]` = readout sequence number. It resets to 0 and increments on each `done_o`.
  - `tdata[ADDR_BITS:0]` = effective length.
  - All other bits are 0.
  - The packet is len+1 beats; `tlast` stays on the final data beat.
- Undefined: no header; the first beat is BRAM word 0.

## Test plan

- **Basic readout:** BRAM preloaded with word k = k. Apply `cap_done_i`=1, `len_i`=16, `start_i` pulse, `tready`=1.
  - Required: 16 beats, data 0..15 on consecutive cycles.
  - Required: `tlast` on data 15, `done_o` 1 cycle later, `busy_o` low afterward.
- **Random backpressure:** `len_i`=0, `tready` 50% random.
  - Required: 2048 beats in order with none lost or duplicated.
  - Required: never more than RD_LATENCY+2 words outstanding.
  - Required: `tdata` stable on every stalled cycle.
- **Rejected start:** `start_i` with `cap_done_i`=0 gives a 1-cycle `start_err_o` and no `bram_en`. `start_i` during RUN is ignored.
- **Length edges:**
  - `len_i`=1: single beat with `tlast`=1.
  - `len_i`=3000: clamped to 2048 beats.
  - Last `bram_addr` is 2047 in both 2048-word cases.
- **Reset mid-operation:** assert `aresetn`=0 at beat 5 of 16.
  - Required: all outputs 0 immediately.
  - Required: a subsequent start produces a clean 16-beat packet from word 0.
- **Header (with `ADC_CAP_READER_HDR_EN` defined):** run two readouts with `len_i`=4.
  - Required: 5 beats per packet.
  - Required: header sequence fields 0 then 1, with length field 4.
